// File: rtl/clause_loader.sv
// -----------------------------------------------------------------------------
// clause_loader
//   Fills the clause register bank before a solve. Coefficient words arrive
//   one at a time over a valid/ready stream. Each clause is assembled into an
//   integer vector (NI variables plus bias) and a boolean vector. The loader
//   then drives the shared clause-index/coefficient bus for one cycle so that
//   only the register with the matching identifier captures the clause.
//
// Ports
//   in_clk                        clock, all state on rising edge
//   in_reset                      synchronous active-high reset
//   in_start                      begin a load run (sampled only in IDLE)
//   in_word_valid / in_word       coefficient stream
//   out_word_ready                word accepted this cycle when valid is high
//   out_clause_index              clause identifier being written, 0 = none
//   out_int_clause_coefficients   assembled integer vector (bias in top slice)
//   out_bool_clause_coefficients  assembled boolean vector
//   out_busy                      high in every state except IDLE
//   out_done                      one-cycle pulse after the last clause write
// -----------------------------------------------------------------------------
module clause_loader #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = 2,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT = 2,
    parameter int NUMBER_OF_INTEGER_VARIABLES              = 2,
    parameter int NUMBER_OF_BOOLEAN_VARIABLES              = 2,
    parameter int NUMBER_OF_CLAUSES                        = 3,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX           = 2,
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int BW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
    localparam int WW = (IW > BW) ? IW : BW,
    localparam int NI = NUMBER_OF_INTEGER_VARIABLES,
    localparam int NB = NUMBER_OF_BOOLEAN_VARIABLES,
    localparam int CIW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 in_start,
    input  logic                 in_word_valid,
    input  logic [WW-1:0]        in_word,
    output logic                 out_word_ready,
    output logic [CIW-1:0]       out_clause_index,
    output logic [IW*(NI+1)-1:0] out_int_clause_coefficients,
    output logic [BW*NB-1:0]     out_bool_clause_coefficients,
    output logic                 out_busy,
    output logic                 out_done
);

    localparam int NWORDS = NI + 1 + NB;
    localparam int WCW    = $clog2(NWORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WCW-1:0]       r_word_cnt;
    logic [CIW-1:0]       r_clause_cnt;
    logic [IW*(NI+1)-1:0] r_int;
    logic [BW*NB-1:0]     r_bool;

    logic w_xfer;
    logic w_last;
    logic w_more;

    assign w_xfer = in_word_valid && (r_state == S_COLLECT);
    assign w_last = (r_word_cnt == WCW'(NWORDS - 1));
    assign w_more = (r_clause_cnt < CIW'(NUMBER_OF_CLAUSES));

    // State register
    always_ff @(posedge in_clk) begin
        if (in_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (in_start) w_next = S_COLLECT;
            S_COLLECT: if (w_xfer && w_last) w_next = S_WRITE;
            S_WRITE:   w_next = w_more ? S_COLLECT : S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Clause and word counters
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_word_cnt   <= '0;
            r_clause_cnt <= '0;
        end else if (r_state == S_IDLE && in_start) begin
            r_word_cnt   <= '0;
            r_clause_cnt <= CIW'(1);
        end else if (w_xfer) begin
            r_word_cnt   <= r_word_cnt + WCW'(1);
        end else if (r_state == S_WRITE && w_more) begin
            r_word_cnt   <= '0;
            r_clause_cnt <= r_clause_cnt + CIW'(1);
        end
    end

    // Word k lands in integer slice k (bias is the last integer word, top
    // slice); the remaining words fill boolean slices low first, truncated.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_int  <= '0;
            r_bool <= '0;
        end else if (w_xfer) begin
            for (int k = 0; k <= NI; k++)
                if (r_word_cnt == WCW'(k))
                    r_int[k*IW +: IW] <= in_word[IW-1:0];
            for (int j = 0; j < NB; j++)
                if (r_word_cnt == WCW'(NI + 1 + j))
                    r_bool[j*BW +: BW] <= in_word[BW-1:0];
        end
    end

    // Outputs are decodes of registered state; buses hold outside WRITE,
    // which is harmless because the index is 0 there.
    assign out_word_ready               = (r_state == S_COLLECT);
    assign out_clause_index             = (r_state == S_WRITE) ? r_clause_cnt : '0;
    assign out_int_clause_coefficients  = r_int;
    assign out_bool_clause_coefficients = r_bool;
    assign out_busy                     = (r_state != S_IDLE);
    assign out_done                     = (r_state == S_DONE);

endmodule

// File: tb/tb_clause_loader.sv
module tb_clause_loader;

    logic       in_clk;
    logic       in_reset;
    logic       in_start;
    logic       in_word_valid;
    logic [1:0] in_word;
    logic       out_word_ready;
    logic [1:0] out_clause_index;
    logic [5:0] out_int_clause_coefficients;
    logic [3:0] out_bool_clause_coefficients;
    logic       out_busy;
    logic       out_done;

    clause_loader dut (
        .in_clk                       (in_clk),
        .in_reset                     (in_reset),
        .in_start                     (in_start),
        .in_word_valid                (in_word_valid),
        .in_word                      (in_word),
        .out_word_ready               (out_word_ready),
        .out_clause_index             (out_clause_index),
        .out_int_clause_coefficients  (out_int_clause_coefficients),
        .out_bool_clause_coefficients (out_bool_clause_coefficients),
        .out_busy                     (out_busy),
        .out_done                     (out_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [1:0] words [15];

    // Clause register bank model (identifiers 1..3) plus an index/transfer log.
    logic [5:0] bank_int  [4];
    logic [3:0] bank_bool [4];
    int         hits      [4];
    logic [1:0] idx_log   [$];
    int         xfers;
    int         wr_rdy;

    always @(negedge in_clk) begin
        if (in_start && !out_busy && !in_reset) begin
            for (int i = 0; i < 4; i++) begin
                hits[i]      = 0;
                bank_int[i]  = '0;
                bank_bool[i] = '0;
            end
            idx_log.delete();
            xfers  = 0;
            wr_rdy = 0;
        end else begin
            if (in_word_valid && out_word_ready) xfers++;
            if (out_clause_index != 2'd0) begin
                idx_log.push_back(out_clause_index);
                hits[out_clause_index]++;
                bank_int[out_clause_index]  = out_int_clause_coefficients;
                bank_bool[out_clause_index] = out_bool_clause_coefficients;
                if (out_word_ready) wr_rdy++;
            end
        end
    end

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Drives one complete run from the words table. done_cyc counts edges from
    // the start edge through the edge after which done is seen (-1 = never).
    task automatic do_run(input int stall, input bit poke, output int done_cyc);
        int cyc;
        done_cyc = -1;
        in_start = 1'b1;
        step();
        cyc = 1;
        in_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (!(c == 0 && k == 0)) begin
                    for (int s = 0; s < stall; s++) begin
                        in_word_valid = 1'b0;
                        in_word       = 2'h3;
                        step();
                        cyc++;
                    end
                end
                in_word_valid = 1'b1;
                in_word       = words[c*5+k];
                if (poke && c == 1 && k == 2) in_start = 1'b1;
                step();
                cyc++;
                in_start = 1'b0;
            end
            // WRITE cycle: valid held high with junk must not transfer
            in_word_valid = 1'b1;
            in_word       = 2'h3;
            step();
            cyc++;
            in_word_valid = 1'b0;
        end
        for (int i = 0; i < 8 && done_cyc < 0; i++) begin
            if (out_done) done_cyc = cyc;
            else begin
                step();
                cyc++;
            end
        end
        if (poke) in_start = 1'b1;
        step();
        in_start = 1'b0;
    endtask

    task automatic load_basic_words();
        logic [1:0] w [15] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2,
                               2'd0, 2'd0, 2'd3, 2'd0, 2'd0,
                               2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
        words = w;
    endtask

    task automatic test_reset();
        in_reset = 1'b1; in_start = 1'b0; in_word_valid = 1'b0; in_word = 2'h0;
        step(); step();
        n_cmp++; if (out_word_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", out_word_ready); end
        n_cmp++; if (out_clause_index !== 2'd0) begin n_fail++; $display("FAIL reset_index got %0d exp 0", out_clause_index); end
        n_cmp++; if (out_int_clause_coefficients !== 6'h00) begin n_fail++; $display("FAIL reset_int got %h exp 00", out_int_clause_coefficients); end
        n_cmp++; if (out_bool_clause_coefficients !== 4'h0) begin n_fail++; $display("FAIL reset_bool got %h exp 0", out_bool_clause_coefficients); end
        n_cmp++; if (out_busy !== 1'b0 || out_done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", out_busy, out_done); end
        in_reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int dc;
        load_basic_words();
        do_run(0, 1'b0, dc);
        n_cmp++; if (bank_int[1] !== 6'h39) begin n_fail++; $display("FAIL basic_c1_int got %h exp 39", bank_int[1]); end
        n_cmp++; if (bank_bool[1] !== 4'h9) begin n_fail++; $display("FAIL basic_c1_bool got %h exp 9", bank_bool[1]); end
        n_cmp++; if (bank_int[2] !== 6'h30 || bank_bool[2] !== 4'h0) begin n_fail++; $display("FAIL basic_c2_bias got %h/%h exp 30/0", bank_int[2], bank_bool[2]); end
        n_cmp++; if (bank_int[3] !== 6'h06 || bank_bool[3] !== 4'h7) begin n_fail++; $display("FAIL basic_c3 got %h/%h exp 06/7", bank_int[3], bank_bool[3]); end
        n_cmp++; if (hits[1] != 1 || hits[2] != 1 || hits[3] != 1) begin n_fail++; $display("FAIL basic_hits got %0d %0d %0d exp 1 1 1", hits[1], hits[2], hits[3]); end
        n_cmp++; if (idx_log.size() != 3 || idx_log[0] != 2'd1 || idx_log[1] != 2'd2 || idx_log[2] != 2'd3) begin n_fail++; $display("FAIL basic_order got size %0d exp 1,2,3", idx_log.size()); end
        n_cmp++; if (dc != 19) begin n_fail++; $display("FAIL basic_done_cycle got %0d exp 19", dc); end
        n_cmp++; if (xfers != 15 || wr_rdy != 0) begin n_fail++; $display("FAIL basic_xfers got %0d/%0d exp 15/0", xfers, wr_rdy); end
        n_cmp++; if (out_busy !== 1'b0 || out_done !== 1'b0) begin n_fail++; $display("FAIL basic_idle got %b%b exp 00", out_busy, out_done); end
    endtask

    task automatic test_stalls();
        int dc;
        load_basic_words();
        do_run(3, 1'b0, dc);
        n_cmp++; if (bank_int[1] !== 6'h39 || bank_bool[1] !== 4'h9) begin n_fail++; $display("FAIL stall_c1 got %h/%h exp 39/9", bank_int[1], bank_bool[1]); end
        n_cmp++; if (bank_int[2] !== 6'h30 || bank_int[3] !== 6'h06 || bank_bool[3] !== 4'h7) begin n_fail++; $display("FAIL stall_c23 got %h/%h/%h exp 30/06/7", bank_int[2], bank_int[3], bank_bool[3]); end
        n_cmp++; if (xfers != 15 || wr_rdy != 0) begin n_fail++; $display("FAIL stall_xfers got %0d/%0d exp 15/0", xfers, wr_rdy); end
        n_cmp++; if (dc != 19 + 42) begin n_fail++; $display("FAIL stall_done_cycle got %0d exp 61", dc); end
    endtask

    task automatic test_reset_midrun();
        int dc;
        load_basic_words();
        in_start = 1'b1; step(); in_start = 1'b0;
        for (int k = 0; k < 5; k++) begin in_word_valid = 1'b1; in_word = words[k]; step(); end
        in_word_valid = 1'b0; step();
        for (int k = 5; k < 7; k++) begin in_word_valid = 1'b1; in_word = words[k]; step(); end
        in_word_valid = 1'b0;
        in_reset = 1'b1; step(); in_reset = 1'b0;
        n_cmp++; if (out_busy !== 1'b0 || out_word_ready !== 1'b0 || out_done !== 1'b0 || out_clause_index !== 2'd0)
            begin n_fail++; $display("FAIL midrst_ctrl got busy%b rdy%b done%b idx%0d exp all 0", out_busy, out_word_ready, out_done, out_clause_index); end
        n_cmp++; if (out_int_clause_coefficients !== 6'h00 || out_bool_clause_coefficients !== 4'h0)
            begin n_fail++; $display("FAIL midrst_bus got %h/%h exp 00/0", out_int_clause_coefficients, out_bool_clause_coefficients); end
        step();
        words[0] = 2'd3; words[1] = 2'd0; words[2] = 2'd1; words[3] = 2'd2; words[4] = 2'd1;
        do_run(0, 1'b0, dc);
        // clause 1 = 3,0,1 | 2,1 -> int 01_00_11, bool 01_10
        n_cmp++; if (hits[1] != 1 || bank_int[1] !== 6'h13 || bank_bool[1] !== 4'h6) begin n_fail++; $display("FAIL midrst_reload got hits%0d %h/%h exp 1 13/6", hits[1], bank_int[1], bank_bool[1]); end
        n_cmp++; if (dc != 19) begin n_fail++; $display("FAIL midrst_done_cycle got %0d exp 19", dc); end
    endtask

    task automatic test_start_busy();
        int dc;
        load_basic_words();
        do_run(0, 1'b1, dc);
        n_cmp++; if (idx_log.size() != 3 || idx_log[0] != 2'd1 || idx_log[2] != 2'd3) begin n_fail++; $display("FAIL busystart_order got size %0d exp 3", idx_log.size()); end
        n_cmp++; if (bank_int[2] !== 6'h30 || bank_int[3] !== 6'h06 || dc != 19) begin n_fail++; $display("FAIL busystart_run got %h/%h/%0d exp 30/06/19", bank_int[2], bank_int[3], dc); end
        n_cmp++; if (out_busy !== 1'b0) begin n_fail++; $display("FAIL busystart_idle got busy %b exp 0", out_busy); end
    endtask

    task automatic test_index_sweep();
        int dc;
        logic [5:0] ei;
        logic [3:0] eb;
        for (int i = 0; i < 15; i++) words[i] = 2'($urandom_range(0, 3));
        do_run(1, 1'b0, dc);
        for (int c = 0; c < 3; c++) begin
            ei = {words[c*5+2], words[c*5+1], words[c*5]};
            eb = {words[c*5+4], words[c*5+3]};
            n_cmp++; if (bank_int[c+1] !== ei || bank_bool[c+1] !== eb || hits[c+1] != 1)
                begin n_fail++; $display("FAIL sweep_clause%0d got %h/%h hits%0d exp %h/%h hits1", c+1, bank_int[c+1], bank_bool[c+1], hits[c+1], ei, eb); end
        end
        n_cmp++; if (idx_log.size() != 3 || hits[0] != 0) begin n_fail++; $display("FAIL sweep_writes got %0d exp 3", idx_log.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_reset_midrun();
        test_start_busy();
        test_index_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
